// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
//   state_e : sequencer states (idle / run / done), 2-bit encoding
//   ADD/SUB : values of in_a_ns selecting add or subtract
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic ADD = 1'b1;
  localparam logic SUB = 1'b0;

endpackage

// File: rtl/addsub_bit.sv
// Single-bit full adder cell, time-shared over all bit positions by the sequencer.
//   a_i, b_i, cin_i : operand bits and incoming carry
//   s_o, cout_o     : sum bit and outgoing carry (majority of the inputs)
module addsub_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial W-bit add/subtract unit. Operands are accepted on a valid/ready handshake,
// processed LSB-first through one full-adder cell (one bit per clock), and the result,
// carry-out and signed overflow are offered on an output valid/ready handshake.
// Optional build macro ADDSUB_SAT_EN: saturate out_s to the signed limit on overflow.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : operand handshake (ready only when idle)
//   in_a, in_b, in_a_ns    : operands; in_a_ns = 1 add, 0 subtract
//   out_valid/out_ready    : result handshake (valid only when done)
//   out_s, out_cout, out_ovf : result, carry out of MSB (sub: 1 = no borrow), overflow
//   busy                   : operation in progress or result pending
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter  int unsigned W     = 8,
  localparam int unsigned CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_a_ns,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_s,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(W - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     sa_q, sa_d;
  logic [W-1:0]     sb_q, sb_d;
  logic [W-1:0]     res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic             s_bit, cout_bit;

  addsub_bit u_cell (
    .a_i   (sa_q[0]),
    .b_i   (sb_q[0]),
    .cin_i (carry_q),
    .s_o   (s_bit),
    .cout_o(cout_bit)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sa_d    = in_a;
          // Subtract as A + ~B + 1: invert B here, inject the +1 as the initial carry.
          sb_d    = (in_a_ns == ADD) ? in_b : ~in_b;
          carry_d = ~in_a_ns;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = {s_bit, res_q[W-1:1]};
        carry_d = cout_bit;
        if (cnt_q == LastBit) begin
          // Carry into the MSB, needed for signed overflow detection.
          c_msb_d = carry_q;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  // In DONE the carry flop holds the carry out of the MSB and is not updated again.
  assign out_cout  = carry_q;
  assign out_ovf   = c_msb_q ^ carry_q;

`ifdef ADDSUB_SAT_EN
  localparam logic [W-1:0] SatMax = {1'b0, {(W - 1) {1'b1}}};
  // On overflow the wrapped result's sign is the opposite of A's sign, so a set
  // result MSB means A was non-negative and the positive limit applies.
  assign out_s = out_ovf ? (res_q[W-1] ? SatMax : ~SatMax) : res_q;
`else
  assign out_s = res_q;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
module tb_serial_addsub_ctrl;
  import serial_addsub_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_a_ns;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  serial_addsub_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_a_ns  (in_a_ns),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ns,
                       output logic [W-1:0] s, output logic c, output logic v);
    int ua, ub, sa, sb, full, r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (ns == ADD) begin
      full = ua + ub;
      c    = (full >= (1 << W));
      r    = sa + sb;
    end else begin
      full = ua - ub;
      c    = (ua >= ub);
      r    = sa - sb;
    end
    s = full[W-1:0];
    v = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
`ifdef ADDSUB_SAT_EN
    if (v) s = (r > 0) ? W'((1 << (W - 1)) - 1) : W'(1 << (W - 1));
`endif
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ns);
    logic [W-1:0] es;
    logic         ec, ev;
    model(a, b, ns, es, ec, ev);
    check({tag, ".s"}, 64'(out_s), 64'(es));
    check({tag, ".cout"}, 64'(out_cout), 64'(ec));
    check({tag, ".ovf"}, 64'(out_ovf), 64'(ev));
  endtask

  // Wait (bounded) for out_valid, sampling #1 after each edge; returns edges counted.
  task automatic wait_done(inout int lat);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  // One full operation: accept, latency check, optional backpressure, result, handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ns, input int hold);
    int g, lat;
    logic [W-1:0] s0;
    logic         c0, v0;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    in_a      = a;
    in_b      = b;
    in_a_ns   = ns;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);  // accept edge counts as edge 1
    lat = 1;
    #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_a_ns  = 1'($urandom);
    wait_done(lat);
    check({tag, ".latency"}, 64'(lat), 64'(W + 1));
    check_result(tag, a, b, ns);
    if (hold > 0) begin
      s0 = out_s;
      c0 = out_cout;
      v0 = out_ovf;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'($urandom);
        @(posedge clk);
        #1;
        check({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
        check({tag, ".hold_ready"}, 64'(in_ready), 64'(0));
        check({tag, ".hold_frozen"}, {62'(out_s), c0 ^ out_cout, v0 ^ out_ovf},
              {62'(s0), 2'b00});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);  // handshake
    #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 64'(out_valid), 64'(0));
    check({tag, ".post_ready"}, 64'(in_ready), 64'(1));
    check({tag, ".post_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_a_ns   = ADD;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.ready", 64'(in_ready), 64'(1));
    check("reset.valid", 64'(out_valid), 64'(0));
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.outs", {62'(out_s), out_cout, out_ovf}, 64'(0));
    rst = 1'b0;

    // Directed cases
    run_op("add_35_4a", 8'h35, 8'h4A, ADD, 0);
    run_op("add_7f_01", 8'h7F, 8'h01, ADD, 0);
    run_op("sub_10_20", 8'h10, 8'h20, SUB, 0);
    run_op("sub_05_05", 8'h05, 8'h05, SUB, 0);
    run_op("sub_80_01", 8'h80, 8'h01, SUB, 0);
    run_op("backpressure", 8'hC3, 8'h5A, ADD, 5);

    // Reset during RUN bit 3
    @(negedge clk);
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    in_a_ns  = ADD;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.ready", 64'(in_ready), 64'(1));
    check("abort.valid", 64'(out_valid), 64'(0));
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.outs", {62'(out_s), out_cout, out_ovf}, 64'(0));
    run_op("after_abort", 8'h01, 8'h01, ADD, 0);

    // Back-to-back with in_valid held high
    @(negedge clk);
    in_a      = 8'h90;
    in_b      = 8'h33;
    in_a_ns   = SUB;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    in_a    = 8'h21;
    in_b    = 8'h43;
    in_a_ns = ADD;
    wait_done(lat);
    check("b2b1.latency", 64'(lat), 64'(W + 1));
    check_result("b2b1", 8'h90, 8'h33, SUB);
    @(posedge clk);
    #1;
    check("b2b.idle_gap", 64'(in_ready), 64'(1));
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    check("b2b.second_accept", {62'(0), busy, in_ready}, 64'(2));
    wait_done(lat);
    check("b2b2.latency", 64'(lat), 64'(W + 1));
    check_result("b2b2", 8'h21, 8'h43, ADD);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("b2b2.post_ready", 64'(in_ready), 64'(1));

    // Random operations with random backpressure
    for (int i = 0; i < 40; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
